// File: rtl/wb_dpbram_param.sv
// wb_dpbram_param: true dual-port block RAM with two Wishbone B4 pipelined
// slave ports on one clock, per-byte write selects, and a lane-wise write
// collision policy. An optional sequencer zeroes the whole array after reset
// and keeps both ports stalled while it runs.
module wb_dpbram_param #(
    parameter int DW             = 32,
    parameter int AW             = 10,
    parameter int WR_PRIORITY    = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic            i_clk,
    input  logic            i_reset,
    // port A
    input  logic            i_a_cyc,
    input  logic            i_a_stb,
    input  logic            i_a_we,
    input  logic [AW-1:0]   i_a_addr,
    input  logic [DW-1:0]   i_a_data,
    input  logic [DW/8-1:0] i_a_sel,
    output logic            o_a_stall,
    output logic            o_a_ack,
    output logic [DW-1:0]   o_a_data,
    // port B
    input  logic            i_b_cyc,
    input  logic            i_b_stb,
    input  logic            i_b_we,
    input  logic [AW-1:0]   i_b_addr,
    input  logic [DW-1:0]   i_b_data,
    input  logic [DW/8-1:0] i_b_sel,
    output logic            o_b_stall,
    output logic            o_b_ack,
    output logic [DW-1:0]   o_b_data
);

    localparam int NL = DW / 8;
    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] CNT_ONE = 1;

    typedef enum logic [1:0] {
        ST_RESET,
        ST_CLEAR,
        ST_RUN
    } state_t;

    state_t        state_q, state_d, state_cur;
    logic [AW:0]   clr_cnt_q, clr_cnt_d;
    logic          a_ack_q, a_ack_d;
    logic          b_ack_q, b_ack_d;

    logic          stall;
    logic          clearing;
    logic          a_acc, b_acc;
    logic          a_wr, b_wr;
    logic [AW-1:0] a_addr_eff;
    logic [DW-1:0] a_wdata;
    logic [NL-1:0] a_lane_we, b_lane_we;

    // The first cycle after reset release already belongs to the successor
    // state, so the clear sweep takes exactly DEPTH cycles and a no-clear
    // build is unstalled immediately.
    always_comb begin
        state_cur = state_q;
        if (state_q == ST_RESET && !i_reset) begin
            state_cur = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
        end
    end

    // Next state and clear counter; reset overrides everything.
    always_comb begin
        state_d   = state_cur;
        clr_cnt_d = clr_cnt_q;
        if (state_cur == ST_CLEAR) begin
            clr_cnt_d = clr_cnt_q + CNT_ONE;
            if (clr_cnt_d[AW]) begin
                state_d = ST_RUN;
            end
        end
        if (i_reset) begin
            state_d   = ST_RESET;
            clr_cnt_d = '0;
        end
    end

    // Request acceptance and write-port steering; the clear sweep borrows
    // port A's write path since both ports are stalled while it runs.
    always_comb begin
        stall      = (state_cur != ST_RUN);
        clearing   = (state_cur == ST_CLEAR) && !i_reset;
        // a request seen in the reset-assertion cycle is dropped entirely
        a_acc      = i_a_cyc && i_a_stb && !stall && !i_reset;
        b_acc      = i_b_cyc && i_b_stb && !stall && !i_reset;
        a_wr       = a_acc && i_a_we;
        b_wr       = b_acc && i_b_we;
        a_ack_d    = a_acc;
        b_ack_d    = b_acc;
        a_addr_eff = clearing ? clr_cnt_q[AW-1:0] : i_a_addr;
        a_wdata    = clearing ? '0 : i_a_data;
        a_lane_we  = '0;
        if (clearing) begin
            a_lane_we = '1;
        end else if (a_wr) begin
            a_lane_we = i_a_sel;
        end
        b_lane_we = b_wr ? i_b_sel : '0;
    end

    // Control registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= ST_RESET;
            clr_cnt_q <= '0;
            a_ack_q   <= 1'b0;
            b_ack_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            a_ack_q   <= a_ack_d;
            b_ack_q   <= b_ack_d;
        end
    end

    assign o_a_stall = stall;
    assign o_b_stall = stall;
    // an ack whose cycle has been dropped by the master is suppressed
    assign o_a_ack   = a_ack_q && i_a_cyc;
    assign o_b_ack   = b_ack_q && i_b_cyc;

    // One byte-wide RAM per lane so each lane resolves collisions on its own.
    genvar gi;
    generate
        for (gi = 0; gi < NL; gi++) begin : g_lane
            logic [7:0] mem [DEPTH];
            logic [7:0] a_rd_q;
            logic [7:0] b_rd_q;

            if (WR_PRIORITY == 0) begin : g_a_wins
                // Lane writes; port A is applied last so it wins a shared lane.
                always_ff @(posedge i_clk) begin
                    if (b_lane_we[gi]) mem[i_b_addr] <= i_b_data[gi*8 +: 8];
                    if (a_lane_we[gi]) mem[a_addr_eff] <= a_wdata[gi*8 +: 8];
                end
            end else begin : g_b_wins
                // Lane writes; port B is applied last so it wins a shared lane.
                always_ff @(posedge i_clk) begin
                    if (a_lane_we[gi]) mem[a_addr_eff] <= a_wdata[gi*8 +: 8];
                    if (b_lane_we[gi]) mem[i_b_addr] <= i_b_data[gi*8 +: 8];
                end
            end

            // Registered read-first data, refreshed only on an accepted request.
            always_ff @(posedge i_clk) begin
                if (i_reset) begin
                    a_rd_q <= '0;
                    b_rd_q <= '0;
                end else begin
                    if (a_acc) a_rd_q <= mem[i_a_addr];
                    if (b_acc) b_rd_q <= mem[i_b_addr];
                end
            end

            assign o_a_data[gi*8 +: 8] = a_rd_q;
            assign o_b_data[gi*8 +: 8] = b_rd_q;
        end
    endgenerate

endmodule

// File: tb/tb_wb_dpbram_param.sv
// Bench for wb_dpbram_param (DW=32, AW=4, A wins collisions, clear on reset).
// Expected ack data is queued per port when a request is accepted and popped
// by a negedge monitor that also checks ack timing every cycle.
module tb_wb_dpbram_param;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_cyc, a_stb, a_we, b_cyc, b_stb, b_we;
    logic [3:0]  a_addr, b_addr, a_sel, b_sel;
    logic [31:0] a_data, b_data;
    logic        a_stall, a_ack, b_stall, b_ack;
    logic [31:0] a_rdata, b_rdata;

    logic [31:0] a_rexp, b_rexp;
    logic        a_pend = 1'b0;
    logic        b_pend = 1'b0;
    logic        mon_en = 1'b0;
    logic [31:0] model [16];
    logic [31:0] qa [$];
    logic [31:0] qb [$];
    int          n_checks = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    wb_dpbram_param #(
        .DW(32), .AW(4), .WR_PRIORITY(0), .CLEAR_ON_RESET(1)
    ) dut (
        .i_clk    (clk),
        .i_reset  (rst),
        .i_a_cyc  (a_cyc),
        .i_a_stb  (a_stb),
        .i_a_we   (a_we),
        .i_a_addr (a_addr),
        .i_a_data (a_data),
        .i_a_sel  (a_sel),
        .o_a_stall(a_stall),
        .o_a_ack  (a_ack),
        .o_a_data (a_rdata),
        .i_b_cyc  (b_cyc),
        .i_b_stb  (b_stb),
        .i_b_we   (b_we),
        .i_b_addr (b_addr),
        .i_b_data (b_data),
        .i_b_sel  (b_sel),
        .o_b_stall(b_stall),
        .o_b_ack  (b_ack),
        .o_b_data (b_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int l = 0; l < 4; l++) begin
            if (sel[l]) r[l*8 +: 8] = nw[l*8 +: 8];
        end
        return r;
    endfunction

    task automatic set_a(input logic we, input logic [3:0] addr, input logic [31:0] dat,
                         input logic [3:0] sel, input logic [31:0] rexp);
        a_stb = 1'b1; a_we = we; a_addr = addr; a_data = dat; a_sel = sel; a_rexp = rexp;
    endtask

    task automatic set_b(input logic we, input logic [3:0] addr, input logic [31:0] dat,
                         input logic [3:0] sel, input logic [31:0] rexp);
        b_stb = 1'b1; b_we = we; b_addr = addr; b_data = dat; b_sel = sel; b_rexp = rexp;
    endtask

    // Advance one clock: queue expectations for requests that will be
    // accepted at this edge, update the model (B then A, so A wins lanes).
    task automatic tick();
        logic        acc_a, acc_b;
        logic [31:0] pa, pb;
        acc_a = a_cyc && a_stb && !a_stall && !rst;
        acc_b = b_cyc && b_stb && !b_stall && !rst;
        pa = model[a_addr];
        pb = model[b_addr];
        if (acc_a) qa.push_back(a_we ? pa : a_rexp);
        if (acc_b) qb.push_back(b_we ? pb : b_rexp);
        if (acc_b && b_we) model[b_addr] = merge(model[b_addr], b_data, b_sel);
        if (acc_a && a_we) model[a_addr] = merge(model[a_addr], a_data, a_sel);
        @(posedge clk);
        #1;
        a_pend = acc_a;
        b_pend = acc_b;
        a_stb  = 1'b0;
        b_stb  = 1'b0;
    endtask

    // Count stalled cycles after reset release while offering requests that
    // must never be acked; bounded so a stuck stall still terminates.
    task automatic measure_clear(input string tag);
        int cnt;
        cnt = 0;
        while (a_stall && cnt < 100) begin
            set_a(1'b0, 4'd0, 32'h0, 4'h0, 32'h0);
            set_b(1'b1, 4'd1, 32'hFFFFFFFF, 4'hF, 32'h0);
            tick();
            cnt++;
        end
        check(tag, 32'(cnt), 32'd16);
        for (int i = 0; i < 16; i++) model[i] = 32'h0;
    endtask

    // Monitor: ack must follow acceptance by one cycle unless cyc dropped.
    always @(negedge clk) begin
        logic [31:0] e;
        if (mon_en) begin
            check("a_ack", 32'(a_ack), 32'(a_pend && a_cyc));
            check("b_ack", 32'(b_ack), 32'(b_pend && b_cyc));
            if (a_pend) begin
                check("a_q_nonempty", 32'(qa.size() > 0), 32'd1);
                if (qa.size() > 0) begin
                    e = qa.pop_front();
                    if (a_ack) check("a_data", a_rdata, e);
                end
            end
            if (b_pend) begin
                check("b_q_nonempty", 32'(qb.size() > 0), 32'd1);
                if (qb.size() > 0) begin
                    e = qb.pop_front();
                    if (b_ack) check("b_data", b_rdata, e);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        a_cyc = 1'b1; a_stb = 1'b0; a_we = 1'b0; a_addr = '0; a_data = '0; a_sel = '0;
        b_cyc = 1'b1; b_stb = 1'b0; b_we = 1'b0; b_addr = '0; b_data = '0; b_sel = '0;
        a_rexp = '0; b_rexp = '0;
        for (int i = 0; i < 16; i++) model[i] = 32'h0;

        // reset state
        repeat (3) tick();
        mon_en = 1'b1;
        check("rst_a_stall", 32'(a_stall), 32'd1);
        check("rst_b_stall", 32'(b_stall), 32'd1);
        check("rst_a_data", a_rdata, 32'h0);
        check("rst_b_data", b_rdata, 32'h0);

        // clear sweep
        rst = 1'b0;
        measure_clear("clear_len");
        check("run_b_stall", 32'(b_stall), 32'd0);
        for (int i = 0; i < 16; i++) begin
            set_a(1'b0, 4'(i), 32'h0, 4'h0, 32'h0);
            tick();
        end
        repeat (2) tick();

        // pipelined write burst then read burst
        for (int i = 0; i < 4; i++) begin
            set_a(1'b1, 4'(i), 32'h11111111 * (i + 1), 4'hF, 32'h0);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            set_a(1'b0, 4'(i), 32'h0, 4'h0, 32'h11111111 * (i + 1));
            tick();
        end
        repeat (2) tick();

        // byte lanes
        set_a(1'b1, 4'd9, 32'hAABBCCDD, 4'hF, 32'h0); tick();
        set_a(1'b1, 4'd9, 32'h00000011, 4'h1, 32'h0); tick();
        set_a(1'b0, 4'd9, 32'h0, 4'h0, 32'hAABBCC11); tick();
        set_a(1'b1, 4'd9, 32'hFFFFFFFF, 4'h0, 32'h0); tick();
        set_a(1'b0, 4'd9, 32'h0, 4'h0, 32'hAABBCC11); tick();
        repeat (2) tick();

        // write/write collisions on address 5
        set_a(1'b1, 4'd5, 32'h12345678, 4'hF, 32'h0);
        set_b(1'b1, 4'd5, 32'h9ABCDEF0, 4'hC, 32'h0);
        tick();
        set_a(1'b0, 4'd5, 32'h0, 4'h0, 32'h12345678); tick();
        set_a(1'b1, 4'd5, 32'h12345678, 4'h3, 32'h0);
        set_b(1'b1, 4'd5, 32'h9ABCDEF0, 4'hC, 32'h0);
        tick();
        set_a(1'b0, 4'd5, 32'h0, 4'h0, 32'h9ABC5678); tick();
        repeat (2) tick();

        // read/write collision, then read/read on address 7
        set_a(1'b1, 4'd7, 32'hCAFEF00D, 4'hF, 32'h0); tick();
        set_a(1'b0, 4'd7, 32'h0, 4'h0, 32'hCAFEF00D);
        set_b(1'b1, 4'd7, 32'hDEADBEEF, 4'hF, 32'h0);
        tick();
        set_a(1'b0, 4'd7, 32'h0, 4'h0, 32'hDEADBEEF); tick();
        set_a(1'b0, 4'd7, 32'h0, 4'h0, 32'hDEADBEEF);
        set_b(1'b0, 4'd7, 32'h0, 4'h0, 32'hDEADBEEF);
        tick();
        repeat (2) tick();

        // abort: accepted write, cyc dropped in the ack cycle
        set_a(1'b1, 4'd3, 32'h5A5A5A5A, 4'hF, 32'h0); tick();
        a_cyc = 1'b0;
        tick();
        a_cyc = 1'b1;
        tick();
        set_a(1'b0, 4'd3, 32'h0, 4'h0, 32'h5A5A5A5A); tick();
        repeat (2) tick();

        // reset asserted with a request presented: no ack may follow
        set_a(1'b1, 4'd2, 32'hFFFFFFFF, 4'hF, 32'h0);
        rst = 1'b1;
        tick();
        check("rst2_a_stall", 32'(a_stall), 32'd1);
        check("rst2_a_data", a_rdata, 32'h0);
        tick();
        rst = 1'b0;
        repeat (8) tick();
        // reset at clear cycle 8: stall stays up, sweep restarts in full
        rst = 1'b1;
        check("midclr_stall", 32'(a_stall), 32'd1);
        tick();
        check("midclr_rst_stall", 32'(a_stall), 32'd1);
        tick();
        rst = 1'b0;
        measure_clear("clear_len_restart");
        set_a(1'b0, 4'd9, 32'h0, 4'h0, 32'h0); tick();
        set_a(1'b0, 4'd2, 32'h0, 4'h0, 32'h0); tick();
        repeat (3) tick();

        check("a_q_drained", 32'(qa.size()), 32'd0);
        check("b_q_drained", 32'(qb.size()), 32'd0);
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/wb_dpbram_param.md
Name: wb_dpbram_param

Overview:
- Parametrised true dual-port block RAM with two independent Wishbone B4 pipelined slave ports, A and B, on a single clock.
- Successor to the fixed 8-bit wbDPBRAM. Adds:
  - configurable data width and depth
  - per-byte write selects
  - a defined same-address collision policy
  - an optional post-reset memory-clear sequencer that stalls both ports.
- Sits between two bus masters (e.g. CPU and DMA) sharing a scratch buffer.

Parameters:
- DW, 32, data width in bits; must be a multiple of 8; DW/8 byte lanes.
- AW, 10, word address width; depth = 2^AW words.
- WR_PRIORITY, 0, winning port for same-address, same-lane simultaneous writes (0 = A, 1 = B).
- CLEAR_ON_RESET, 1, 1 = zero entire memory after reset release; 0 = contents untouched by reset.

Ports:
- i_clk  in  1  clock; all logic rising-edge.
- i_reset  in  1  synchronous, active-high reset.
- i_a_cyc  in  1  port A bus cycle.
- i_a_stb  in  1  port A strobe.
- i_a_we  in  1  port A write enable.
- i_a_addr  in  AW  port A word address.
- i_a_data  in  DW  port A write data.
- i_a_sel  in  DW/8  port A byte selects.
- o_a_stall  out  1  port A stall.
- o_a_ack  out  1  port A acknowledge.
- o_a_data  out  DW  port A read data.
- i_b_cyc, i_b_stb, i_b_we, i_b_addr, i_b_data, i_b_sel, o_b_stall, o_b_ack, o_b_data: identical to port A, for port B.

Behaviour:
- Acceptance per port: cyc & stb & !stall at a rising edge. One request per cycle per port; back-to-back pipelined requests allowed.
- Latency: o_x_ack asserts exactly 1 cycle after acceptance, for 1 cycle per accepted request.
- Read data:
  - o_x_data is valid in the ack cycle and holds its value until the next ack on that port.
  - A write ack returns the word's prior contents (read-first).
- Abort: if i_x_cyc is low in the cycle o_x_ack would assert, ack is forced 0. A write already accepted is still committed.
- Writes update only the byte lanes whose sel bit is 1. sel = 0 with we = 1 is still acked, and memory is unchanged.
- Same-address collisions (both ports accept the same address in one cycle):
  - write/write: each lane selected by only one port takes that port's data; lanes selected by both take the WR_PRIORITY port's data.
  - read/write: the read returns old contents (read-first); the new value is visible from the next access.
  - read/read: both return identical data.
- Address width: addresses are exactly AW bits, with no aliasing beyond depth.
- FSM states:
  - RESET: entered while i_reset = 1.
    - o_a_ack = o_b_ack = 0; o_a_data = o_b_data = 0; o_a_stall = o_b_stall = 1.
    - Clear counter = 0.
  - CLEAR: entered on the first cycle after i_reset falls, if CLEAR_ON_RESET = 1.
    - Writes zero to counter address each cycle; counter increments by 1.
    - Both stalls held at 1.
    - Exits to RUN after writing address 2^AW-1, so CLEAR lasts exactly 2^AW cycles; the counter is AW+1 bits to detect the wrap.
  - RUN: stalls = 0; normal operation.
    - Entered directly from RESET when CLEAR_ON_RESET = 0, with stall low on the first cycle after reset release.
- Reset mid-operation:
  - i_reset in any state returns to RESET on the next edge.
  - Pending acks are dropped and outputs return to reset values.
  - A CLEAR in progress restarts from address 0.
  - Requests accepted in the reset-assertion cycle are discarded, with no write.
- No ack is ever produced for a request presented while stall = 1.

Test Plan:
- Clear sweep: DW = 32, AW = 4, CLEAR_ON_RESET = 1; release reset.
  - Required: stall high exactly 16 cycles, then low.
  - Port A reads of addresses 0-15 all return 0x00000000, each acked 1 cycle after acceptance.
- Pipelined throughput: port A writes 0x11111111..0x44444444 to addresses 0-3 back-to-back, then reads 0-3 back-to-back.
  - Required: 4 consecutive acks per burst.
  - Read data returns 0x11111111..0x44444444 in order.
- Byte lanes: write 0xAABBCCDD with sel = 4'b1111, then 0x00000011 with sel = 4'b0001, then read.
  - Required: read returns 0xAABBCC11.
- Collision, write/write on address 5, WR_PRIORITY = 0: A writes 0x12345678 with sel = 1111 while B writes 0x9ABCDEF0 with sel = 1100 in the same cycle.
  - Required: subsequent read returns 0x12345678.
  - With A sel = 0011 instead: read returns 0x9ABC5678.
- Read/write collision: address 7 holds 0xCAFEF00D; A reads 7 while B writes 0xDEADBEEF to 7 in the same cycle.
  - Required: A gets 0xCAFEF00D; next A read of 7 gets 0xDEADBEEF.
- Abort and reset:
  - Accepted A write, then cyc low in the ack cycle. Required: no ack, write visible on a later read.
  - Assert reset at CLEAR cycle 8. Required: stall stays high; after release, CLEAR lasts a full 16 cycles.
